// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-source burst arbiter.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } arb_state_t;

    localparam int MAX_BURST_DEFAULT = 8;
    localparam int COUNT_W           = 8;

endpackage

// File: rtl/burst_counter.sv
// Saturating beat counter for the current owner's burst; clr wins over inc.
module burst_counter
    import mux_arb_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    input  logic               clr,
    output logic [COUNT_W-1:0] count,
    output logic               at_max
);

    localparam logic [COUNT_W-1:0] LIMIT = COUNT_W'(MAX_BURST - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign at_max = (count == LIMIT);

endmodule

// File: rtl/mux_select_arbiter.sv
// Two-source burst arbiter driving the select of a downstream 2:1 mux,
// with round-robin tie-break and a forced release after MAX_BURST beats.
module mux_select_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic last_a,
    input  logic req_b,
    input  logic last_b,
    input  logic out_ready,
    output logic mux_select,
    output logic grant_a,
    output logic grant_b,
    output logic out_valid
);

    arb_state_t         state;
    logic               prio_b;
    logic               own_req;
    logic               own_last;
    logic               other_req;
    logic               xfer;
    logic               rel_now;
    logic               at_max;
    logic [COUNT_W-1:0] count;

    assign own_req   = grant_a ? req_a  : req_b;
    assign own_last  = grant_a ? last_a : last_b;
    assign other_req = grant_a ? req_b  : req_a;

    assign out_valid = ~rst & ((grant_a & req_a) | (grant_b & req_b));
    assign xfer      = out_valid & out_ready;

    // Losing the request releases at once; otherwise only an accepted beat can end the burst.
    assign rel_now = (state != IDLE) & (~own_req | (xfer & (own_last | at_max)));

    burst_counter #(
        .MAX_BURST (MAX_BURST)
    ) u_burst_counter (
        .clk    (clk),
        .rst    (rst),
        .inc    (xfer & ~rel_now),
        .clr    (rel_now),
        .count  (count),
        .at_max (at_max)
    );

    always_comb begin
        if (!rst) begin
            assert (count <= COUNT_W'(MAX_BURST - 1));
        end
    end

    // Grants and select are registered alongside the state so no input reaches them combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant_a    <= 1'b0;
            grant_b    <= 1'b0;
            mux_select <= 1'b0;
            prio_b     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_a && (!req_b || !prio_b)) begin
                        state      <= OWN_A;
                        grant_a    <= 1'b1;
                        mux_select <= 1'b0;
                    end else if (req_b) begin
                        state      <= OWN_B;
                        grant_b    <= 1'b1;
                        mux_select <= 1'b1;
                    end
                end
                OWN_A, OWN_B: begin
                    if (rel_now) begin
                        prio_b <= (state == OWN_A);
                        if (other_req) begin
                            state      <= (state == OWN_A) ? OWN_B : OWN_A;
                            grant_a    <= (state == OWN_B);
                            grant_b    <= (state == OWN_A);
                            mux_select <= (state == OWN_A);
                        end else begin
                            state   <= IDLE;
                            grant_a <= 1'b0;
                            grant_b <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_a <= 1'b0;
                    grant_b <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Randomized bench for mux_select_arbiter against a behavioural ownership model.
module tb_mux_select_arbiter;

    localparam int MB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_a = 1'b0;
    logic       last_a = 1'b0;
    logic       req_b = 1'b0;
    logic       last_b = 1'b0;
    logic       out_ready = 1'b0;
    logic       mux_select;
    logic       grant_a;
    logic       grant_b;
    logic       out_valid;
    logic [7:0] data_a = 8'h00;
    logic [7:0] data_b = 8'h00;
    logic [7:0] data_out;

    // Model: owner 0 = none, 1 = A, 2 = B; beats = transfers in current grant.
    int m_owner;
    int m_beats;
    bit m_ptr_b;
    bit m_msel;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mux_select_arbiter #(
        .MAX_BURST (MB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_a      (req_a),
        .last_a     (last_a),
        .req_b      (req_b),
        .last_b     (last_b),
        .out_ready  (out_ready),
        .mux_select (mux_select),
        .grant_a    (grant_a),
        .grant_b    (grant_b),
        .out_valid  (out_valid)
    );

    assign data_out = mux_select ? data_b : data_a;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_owner = 0;
        m_beats = 0;
        m_ptr_b = 1'b0;
        m_msel  = 1'b0;
    endtask

    task automatic checkOutput();
        bit exp_valid;
        exp_valid = (m_owner == 1 && req_a) || (m_owner == 2 && req_b);
        chk("grant_a", int'(grant_a), int'(m_owner == 1));
        chk("grant_b", int'(grant_b), int'(m_owner == 2));
        chk("mux_select", int'(mux_select), int'(m_msel));
        chk("out_valid", int'(out_valid), int'(exp_valid));
        chk("grant_exclusive", int'(grant_a & grant_b), 0);
        if (exp_valid) begin
            chk("mux_data", int'(data_out), (m_owner == 2) ? int'(data_b) : int'(data_a));
        end
    endtask

    // Called at a falling edge; returns at the next falling edge with the model advanced.
    task automatic applyStimulus(input bit a, input bit la, input bit b, input bit lb, input bit rdy);
        int  own;
        int  beats;
        bit  ptr_b;
        bit  msel;
        bit  my_req;
        bit  my_last;
        bit  oth_req;
        bit  xfer;
        bit  rel;
        req_a     = a;
        last_a    = la;
        req_b     = b;
        last_b    = lb;
        out_ready = rdy;
        data_a    = 8'($urandom);
        data_b    = 8'($urandom);
        #1;
        checkOutput();
        own   = m_owner;
        beats = m_beats;
        ptr_b = m_ptr_b;
        msel  = m_msel;
        if (own == 0) begin
            if (a && b)  own = ptr_b ? 2 : 1;
            else if (a)  own = 1;
            else if (b)  own = 2;
            if (own != 0) msel = (own == 2);
            beats = 0;
        end else begin
            my_req  = (own == 1) ? a  : b;
            my_last = (own == 1) ? la : lb;
            oth_req = (own == 1) ? b  : a;
            xfer    = my_req && rdy;
            rel     = !my_req || (xfer && (my_last || (beats + 1 == MB)));
            if (rel) begin
                ptr_b = (own == 1);
                beats = 0;
                own   = oth_req ? (3 - own) : 0;
                if (own != 0) msel = (own == 2);
            end else if (xfer) begin
                beats++;
            end
        end
        @(posedge clk);
        m_owner = own;
        m_beats = beats;
        m_ptr_b = ptr_b;
        m_msel  = msel;
        @(negedge clk);
    endtask

    // Asynchronous reset pulse landing between clock edges.
    task automatic resetMid();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_grant_a", int'(grant_a), 0);
        chk("rst_grant_b", int'(grant_b), 0);
        chk("rst_mux_select", int'(mux_select), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        modelReset();
        @(negedge clk);
        chk("por_grant_a", int'(grant_a), 0);
        chk("por_grant_b", int'(grant_b), 0);
        chk("por_mux_select", int'(mux_select), 0);
        chk("por_out_valid", int'(out_valid), 0);
        rst = 1'b0;

        // Single A request, one-beat burst.
        applyStimulus(1, 0, 0, 0, 1);
        chk("a_alone_grant_a", int'(grant_a), 1);
        chk("a_alone_mux", int'(mux_select), 0);
        chk("a_alone_valid", int'(out_valid), 1);
        applyStimulus(1, 1, 0, 0, 1);
        chk("a_last_grant_a", int'(grant_a), 0);
        chk("a_last_grant_b", int'(grant_b), 0);

        // Both requesting with single-beat bursts alternate every cycle.
        resetMid();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 1, 1, 1, 1);
            chk("alt_grant_a", int'(grant_a), (i % 2 == 0) ? 1 : 0);
            chk("alt_grant_b", int'(grant_b), (i % 2 == 1) ? 1 : 0);
            chk("alt_mux", int'(mux_select), i % 2);
        end

        // B bursts without last until the forced release hands over to A.
        resetMid();
        applyStimulus(0, 0, 1, 0, 1);
        n = 0;
        while (grant_b && n < 10) begin
            applyStimulus(1, 0, 1, 0, 1);
            n++;
        end
        chk("forced_burst_len", n, 4);
        chk("forced_then_a", int'(grant_a), 1);

        // Back-pressure stall mid-burst keeps everything frozen.
        resetMid();
        applyStimulus(1, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 0, 0, 0);
            chk("stall_grant_a", int'(grant_a), 1);
            chk("stall_mux", int'(mux_select), 0);
            chk("stall_valid", int'(out_valid), 1);
        end
        applyStimulus(1, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 1);
        chk("stall_count_kept", int'(grant_a), 1);
        applyStimulus(1, 0, 0, 0, 1);
        chk("stall_release", int'(grant_a), 0);

        // Reset during a B burst drops select back to A.
        resetMid();
        applyStimulus(0, 0, 1, 0, 1);
        chk("pre_rst_mux", int'(mux_select), 1);
        resetMid();

        // Dropping the request releases to IDLE with select held.
        applyStimulus(1, 0, 0, 0, 1);
        chk("drop_pre_grant_a", int'(grant_a), 1);
        applyStimulus(0, 0, 0, 0, 1);
        chk("drop_grant_a", int'(grant_a), 0);
        chk("drop_grant_b", int'(grant_b), 0);
        chk("drop_mux", int'(mux_select), 0);

        // Randomized traffic with occasional mid-cycle resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                resetMid();
            end else begin
                applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                              $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                              $urandom_range(0, 9) < 7);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux_select_arbiter.md
MUX_SELECT_ARBITER -- requirements
Module: mux_select_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 8: maximum beats per grant before forced release (legal range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port req_a, input, 1 bit: source A has a beat to send.
REQ-005 SHALL have port last_a, input, 1 bit: current A beat ends A's burst.
REQ-006 SHALL have port req_b, input, 1 bit: source B has a beat to send.
REQ-007 SHALL have port last_b, input, 1 bit: current B beat ends B's burst.
REQ-008 SHALL have port out_ready, input, 1 bit: downstream accepts a beat this cycle.
REQ-009 SHALL have port mux_select, output, 1 bit: select for the downstream 2:1 mux (0 = A, 1 = B).
REQ-010 SHALL have port grant_a, output, 1 bit: A owns the mux.
REQ-011 SHALL have port grant_b, output, 1 bit: B owns the mux.
REQ-012 SHALL have port out_valid, output, 1 bit: the selected beat is valid.

Function
REQ-013 SHALL implement a state machine with states IDLE, OWN_A and OWN_B.
REQ-014 In IDLE, if exactly one of req_a/req_b is high, SHALL move to that source's OWN state next cycle (1-cycle grant latency).
REQ-015 In IDLE with req_a and req_b both high, SHALL grant the source named by the 1-bit priority pointer (0 = A).
REQ-016 grant_a SHALL equal (state == OWN_A), grant_b SHALL equal (state == OWN_B), both registered; they SHALL never be high together.
REQ-017 mux_select SHALL be registered: 0 in OWN_A, 1 in OWN_B, holding its previous value in IDLE; it SHALL never be X or Z after reset.
REQ-018 out_valid SHALL be combinational: (grant_a & req_a) | (grant_b & req_b).
REQ-019 A transfer SHALL be out_valid & out_ready; the beat counter SHALL increment by 1 per transfer and saturate at MAX_BURST-1.
REQ-020 The owner SHALL release on a transfer with its last bit high.
REQ-021 The owner SHALL release on a transfer while the counter equals MAX_BURST-1 (forced release).
REQ-022 The owner SHALL release in any cycle its req is low.
REQ-023 On release, SHALL set the priority pointer to the other source and clear the counter.
REQ-024 On release, SHALL go to the other OWN state if the other req is high that cycle (no idle bubble); otherwise it SHALL go to IDLE.
REQ-025 out_ready low SHALL hold state, counter and mux_select unchanged (no release except per REQ-022).
REQ-026 MAX_BURST = 1 SHALL release after every transfer, alternating sources when both request.

Reset
REQ-027 On rst high, SHALL immediately (asynchronously) force: state IDLE, mux_select 0, grant_a 0, grant_b 0, counter 0, priority pointer A.
REQ-028 out_valid SHALL be 0 while rst is high.
REQ-029 Reset mid-burst SHALL abandon the burst; the first grant after reset SHALL follow IDLE rules.

Structure
REQ-030 The state enum typedef arb_state_t and the MAX_BURST default constant SHALL live in shared package mux_arb_pkg.
REQ-031 The beat counter SHALL be sub-module burst_counter: inputs clk, rst, inc, clr; outputs count and at_max.
REQ-032 The block SHALL contain no combinational path from out_ready to mux_select or to either grant.

Verification (bench instantiates the downstream mux with mux_select)
REQ-033 Reset, then req_a=1 alone -> cycle 1: grant_a=1, mux_select=0, out_valid=1; beat with last_a=1 and out_ready=1 -> next cycle IDLE, all grants 0.
REQ-034 req_a=req_b=1 held, last always 1, out_ready=1 -> grants alternate A, B, A, B every cycle with no IDLE cycle; mux_select toggles 0,1,0,1.
REQ-035 MAX_BURST=4, req_b=1, last_b=0, req_a=1 -> B receives exactly 4 transfers, then A is granted.
REQ-036 OWN_A with out_ready=0 for 5 cycles -> grant_a, mux_select and counter unchanged; out_valid=1 throughout.
REQ-037 rst pulsed mid-burst between clock edges -> grants drop to 0 and mux_select goes to 0 before the next edge.
REQ-038 After reset, drive req_a=1 and last_a=0 into OWN_A, then drop req_a -> next cycle IDLE with mux_select held at 0.
